// File: rtl/c5_mem_pkg.sv
// Shared types and constants for the c5 SRAM responder: FSM states, widths
// and the big-endian byte-lane mapping of a 32-bit word onto two halfwords.
package c5_mem_pkg;
    localparam int HALF_W = 16;
    localparam int WAIT_W = 4;

    // byte_we[3:2] drive the HI halfword (bits 31:16), byte_we[1:0] the LO one
    localparam int BE_HI_LSB = 2;
    localparam int BE_LO_LSB = 0;
    localparam logic [1:0] BE_READ = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        HI,
        LO,
        DONE
    } mem_state_t;
endpackage

// File: rtl/c5_wait_cnt.sv
// Loadable wait-state down-counter; parks at zero and flags it.
module c5_wait_cnt
    import c5_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    output logic              zero
);
    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt <= '0;
        else if (load)       cnt <= load_val;
        else if (cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/c5_mem_ctrl.sv
// c5_cpu bus responder: splits each 32-bit access into HI/LO halfword
// accesses on a 16-bit async SRAM, stalling the CPU while in flight.
module c5_mem_ctrl
    import c5_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int EXT_AW      = 19
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_enable,
    input  logic [31:2]       I_address,
    input  logic [3:0]        I_byte_we,
    input  logic [31:0]       I_data_w,
    output logic [31:0]       O_data_r,
    output logic              O_mem_pause,
    output logic [EXT_AW-1:0] O_ext_addr,
    output logic              O_ext_cs,
    output logic              O_ext_we,
    output logic [1:0]        O_ext_be,
    output logic [15:0]       O_ext_data_w,
    input  logic [15:0]       I_ext_data_r
);
    localparam logic [WAIT_W-1:0] CNT_INIT = WAIT_W'(WAIT_CYCLES - 1);

    mem_state_t        state_q, state_d;
    logic [EXT_AW-2:0] addr_q;
    logic [3:0]        we_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_r_q;
    logic              cnt_load, cnt_zero;
    logic              is_wr, in_xfer, in_lo;
    logic              unused_addr;

    assign unused_addr = ^I_address[31:EXT_AW+1];

    c5_wait_cnt u_wait_cnt (
        .clk      (I_clk),
        .rst_n    (I_rst_n),
        .load     (cnt_load),
        .load_val (CNT_INIT),
        .zero     (cnt_zero)
    );

    assign is_wr   = |we_q;
    assign in_lo   = (state_q == LO);
    assign in_xfer = (state_q == HI) || in_lo;

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        case (state_q)
            IDLE: if (I_enable) begin
                cnt_load = 1'b1;
                // writes that leave the upper halfword untouched go straight to LO
                if ((|I_byte_we) && (I_byte_we[BE_HI_LSB +: 2] == 2'b00)) state_d = LO;
                else                                                      state_d = HI;
            end
            HI: if (cnt_zero) begin
                if (is_wr && (we_q[BE_LO_LSB +: 2] == 2'b00)) begin
                    state_d = DONE;
                end else begin
                    state_d  = LO;
                    cnt_load = 1'b1;
                end
            end
            LO:      if (cnt_zero) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= '0;
            wdata_q  <= '0;
            data_r_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && I_enable) begin
                addr_q  <= I_address[EXT_AW:2];
                we_q    <= I_byte_we;
                wdata_q <= I_data_w;
            end
            if (!is_wr && cnt_zero) begin
                if (state_q == HI)      data_r_q[HALF_W +: HALF_W] <= I_ext_data_r;
                else if (state_q == LO) data_r_q[0 +: HALF_W]      <= I_ext_data_r;
            end
        end
    end

    // Bus side is decoded from the latched request so CPU changes are ignored mid-access
    assign O_data_r     = data_r_q;
    assign O_mem_pause  = I_rst_n && (((state_q == IDLE) && I_enable) || in_xfer);
    assign O_ext_cs     = in_xfer;
    assign O_ext_we     = in_xfer && is_wr;
    assign O_ext_addr   = {addr_q, in_lo};
    assign O_ext_data_w = in_lo ? wdata_q[0 +: HALF_W] : wdata_q[HALF_W +: HALF_W];

    always_comb begin
        O_ext_be = 2'b00;
        if (in_xfer) begin
            if (!is_wr)     O_ext_be = BE_READ;
            else if (in_lo) O_ext_be = we_q[BE_LO_LSB +: 2];
            else            O_ext_be = we_q[BE_HI_LSB +: 2];
        end
    end
endmodule

// File: tb/tb_c5_mem_ctrl.sv
// Directed bench for c5_mem_ctrl: one instance with 2 wait states, one with 1,
// both serviced by a small behavioural SRAM.
module tb_c5_mem_ctrl;
    logic        clk, rst_n, en, en1;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] dr, dr1;
    logic        pause, pause1, cs, cs1, we, we1;
    logic [18:0] ext_addr, ext_addr1;
    logic [1:0]  ext_be, ext_be1;
    logic [15:0] ext_wd, ext_wd1, ext_rd, ext_rd1;

    logic [15:0] sram [0:1023];
    logic        pk;
    logic [9:0]  pk_a;
    logic [15:0] pk_d;

    int total = 0;
    int bad   = 0;

    c5_mem_ctrl #(.WAIT_CYCLES(2), .EXT_AW(19)) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_enable(en), .I_address(addr),
        .I_byte_we(be), .I_data_w(wd), .O_data_r(dr), .O_mem_pause(pause),
        .O_ext_addr(ext_addr), .O_ext_cs(cs), .O_ext_we(we), .O_ext_be(ext_be),
        .O_ext_data_w(ext_wd), .I_ext_data_r(ext_rd)
    );

    c5_mem_ctrl #(.WAIT_CYCLES(1), .EXT_AW(19)) dut1 (
        .I_clk(clk), .I_rst_n(rst_n), .I_enable(en1), .I_address(addr),
        .I_byte_we(be), .I_data_w(wd), .O_data_r(dr1), .O_mem_pause(pause1),
        .O_ext_addr(ext_addr1), .O_ext_cs(cs1), .O_ext_we(we1), .O_ext_be(ext_be1),
        .O_ext_data_w(ext_wd1), .I_ext_data_r(ext_rd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ext_rd  = sram[ext_addr[9:0]];
    assign ext_rd1 = sram[ext_addr1[9:0]];

    always @(posedge clk) begin
        if (pk) sram[pk_a] <= pk_d;
        else if (cs && we) begin
            if (ext_be[1]) sram[ext_addr[9:0]][15:8] <= ext_wd[15:8];
            if (ext_be[0]) sram[ext_addr[9:0]][7:0]  <= ext_wd[7:0];
        end
    end

    task automatic poke(input logic [9:0] a, input logic [15:0] d);
        @(negedge clk); pk_a = a; pk_d = d; pk = 1'b1;
        @(negedge clk); pk = 1'b0;
    endtask

    // Runs one access on dut; returns at the first unpaused (DONE) cycle.
    task automatic do_access(input logic [29:0] a, input logic [3:0] b, input logic [31:0] d,
                             output int np, output bit saw_we, output bit hi_seen, output bit lo_seen,
                             output logic [1:0] bh, output logic [1:0] bl, output bit tmo);
        np = 0; saw_we = 0; hi_seen = 0; lo_seen = 0; bh = 2'b00; bl = 2'b00; tmo = 1;
        @(negedge clk); addr = a; be = b; wd = d; en = 1'b1; #1;
        for (int i = 0; i < 40; i++) begin
            if (!pause) begin tmo = 0; break; end
            np++;
            if (we) saw_we = 1;
            if (cs && !ext_addr[0]) begin hi_seen = 1; bh = ext_be; end
            if (cs && ext_addr[0])  begin lo_seen = 1; bl = ext_be; end
            @(negedge clk); #1;
            en = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; en1 = 1'b0; addr = '0; be = '0; wd = '0; pk = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b1; #1;
        total++; if (pause !== 1'b0) begin bad++; $display("FAIL rst_pause got=%b exp=0", pause); end
        total++; if ({cs, we, ext_be} !== 4'b0) begin bad++; $display("FAIL rst_ctl got=%b exp=0000", {cs, we, ext_be}); end
        total++; if (ext_addr !== 19'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", ext_addr); end
        total++; if (ext_wd !== 16'h0) begin bad++; $display("FAIL rst_wd got=%h exp=0", ext_wd); end
        total++; if (dr !== 32'h0) begin bad++; $display("FAIL rst_dr got=%h exp=0", dr); end
        en = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        total++; if (pause !== 1'b0) begin bad++; $display("FAIL post_rst_pause got=%b exp=0", pause); end
    endtask

    task automatic test_read;
        int np; bit sw, hs, ls, tmo; logic [1:0] bh, bl;
        poke(10'h200, 16'hDEAD);
        poke(10'h201, 16'hBEEF);
        do_access(30'h100, 4'h0, 32'h0, np, sw, hs, ls, bh, bl, tmo);
        total++; if (tmo) begin bad++; $display("FAIL read_timeout got=stuck exp=done"); end
        total++; if (dr !== 32'hDEADBEEF) begin bad++; $display("FAIL read_data got=%h exp=deadbeef", dr); end
        total++; if (np !== 5) begin bad++; $display("FAIL read_pause got=%0d exp=5", np); end
        total++; if (sw !== 1'b0) begin bad++; $display("FAIL read_we got=%b exp=0", sw); end
        total++; if ({hs, ls, bh, bl} !== 6'b11_11_11) begin bad++; $display("FAIL read_phases got=%b exp=111111", {hs, ls, bh, bl}); end
    endtask

    task automatic test_idle;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); addr = 30'($urandom); be = 4'($urandom); #1;
            total++; if ({pause, cs} !== 2'b00) begin bad++; $display("FAIL idle_%0d got=%b exp=00", i, {pause, cs}); end
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] p;
        poke(10'h200, 16'hDEAD);
        @(negedge clk); addr = 30'h100; be = 4'h0; en = 1'b1; #1;
        for (int i = 0; i < 12; i++) begin
            p[i] = pause;
            if (i == 5) begin
                total++; if (dr !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_data got=%h exp=deadbeef", dr); end
            end
            if (i < 11) begin @(negedge clk); #1; end
        end
        en = 1'b0;
        total++; if (p !== 12'h7DF) begin bad++; $display("FAIL b2b_pattern got=%h exp=7df", p); end
    endtask

    task automatic test_write;
        int np; bit sw, hs, ls, tmo; logic [1:0] bh, bl;
        do_access(30'h100, 4'hF, 32'h12345678, np, sw, hs, ls, bh, bl, tmo);
        total++; if (tmo || np !== 5) begin bad++; $display("FAIL wr_pause got=%0d exp=5", np); end
        total++; if ({bh, bl} !== 4'b1111) begin bad++; $display("FAIL wr_be got=%b exp=1111", {bh, bl}); end
        total++; if (sram[10'h200] !== 16'h1234) begin bad++; $display("FAIL wr_hi got=%h exp=1234", sram[10'h200]); end
        total++; if (sram[10'h201] !== 16'h5678) begin bad++; $display("FAIL wr_lo got=%h exp=5678", sram[10'h201]); end
        total++; if (dr !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_dr_hold got=%h exp=deadbeef", dr); end
    endtask

    task automatic test_byte_write;
        int np; bit sw, hs, ls, tmo; logic [1:0] bh, bl;
        do_access(30'h100, 4'b0100, 32'h00AB0000, np, sw, hs, ls, bh, bl, tmo);
        total++; if (tmo || np !== 3) begin bad++; $display("FAIL bw_pause got=%0d exp=3", np); end
        total++; if ({hs, ls} !== 2'b10) begin bad++; $display("FAIL bw_phases got=%b exp=10", {hs, ls}); end
        total++; if (bh !== 2'b01) begin bad++; $display("FAIL bw_be got=%b exp=01", bh); end
        total++; if (sram[10'h200] !== 16'h12AB) begin bad++; $display("FAIL bw_hi got=%h exp=12ab", sram[10'h200]); end
        total++; if (sram[10'h201] !== 16'h5678) begin bad++; $display("FAIL bw_lo got=%h exp=5678", sram[10'h201]); end
    endtask

    task automatic test_reset_mid;
        bit tmo;
        poke(10'h202, 16'h0000);
        poke(10'h203, 16'h0000);
        @(negedge clk); addr = 30'h101; be = 4'hF; wd = 32'hAAAA5555; en = 1'b1;
        @(negedge clk); #1;
        total++; if ({cs, we, ext_addr} !== {2'b11, 19'h202}) begin bad++; $display("FAIL rm_hi got=%b%b/%h exp=11/202", cs, we, ext_addr); end
        #2 rst_n = 1'b0; #1;
        total++; if ({cs, we, pause, ext_be} !== 5'b0) begin bad++; $display("FAIL rm_async got=%b exp=00000", {cs, we, pause, ext_be}); end
        @(negedge clk); #1;
        total++; if (cs !== 1'b0) begin bad++; $display("FAIL rm_hold_cs got=%b exp=0", cs); end
        @(negedge clk); rst_n = 1'b1; #1;
        total++; if (pause !== 1'b1) begin bad++; $display("FAIL rm_restart_pause got=%b exp=1", pause); end
        total++; if (sram[10'h203] !== 16'h0000) begin bad++; $display("FAIL rm_no_lo got=%h exp=0000", sram[10'h203]); end
        @(negedge clk); #1;
        total++; if ({cs, ext_addr} !== {1'b1, 19'h202}) begin bad++; $display("FAIL rm_fresh_hi got=%b/%h exp=1/202", cs, ext_addr); end
        en = 1'b0; tmo = 1;
        for (int i = 0; i < 10; i++) begin
            if (!pause) begin tmo = 0; break; end
            @(negedge clk); #1;
        end
        total++; if (tmo) begin bad++; $display("FAIL rm_timeout got=stuck exp=done"); end
        total++; if ({sram[10'h202], sram[10'h203]} !== 32'hAAAA5555) begin bad++; $display("FAIL rm_fresh_data got=%h%h exp=aaaa5555", sram[10'h202], sram[10'h203]); end
    endtask

    task automatic test_addr_change;
        poke(10'h300, 16'hCAFE);
        poke(10'h301, 16'hF00D);
        @(negedge clk); addr = 30'h180; be = 4'h0; wd = 32'h0; en1 = 1'b1; #1;
        total++; if (pause1 !== 1'b1) begin bad++; $display("FAIL ac_idle_pause got=%b exp=1", pause1); end
        @(negedge clk); #1;
        total++; if ({cs1, we1, ext_be1, ext_addr1} !== {4'b1011, 19'h300}) begin bad++; $display("FAIL ac_hi got=%b/%h exp=1011/300", {cs1, we1, ext_be1}, ext_addr1); end
        addr = 30'h3FF; wd = 32'hFFFFFFFF; en1 = 1'b0;
        @(negedge clk); #1;
        total++; if ({pause1, ext_addr1} !== {1'b1, 19'h301}) begin bad++; $display("FAIL ac_lo got=%b/%h exp=1/301", pause1, ext_addr1); end
        total++; if (ext_wd1 !== 16'h0000) begin bad++; $display("FAIL ac_wd got=%h exp=0000", ext_wd1); end
        @(negedge clk); #1;
        total++; if (pause1 !== 1'b0) begin bad++; $display("FAIL ac_done got=%b exp=0", pause1); end
        total++; if (dr1 !== 32'hCAFEF00D) begin bad++; $display("FAIL ac_data got=%h exp=cafef00d", dr1); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_idle();
        test_back_to_back();
        test_write();
        test_byte_write();
        test_reset_mid();
        test_addr_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/c5_mem_ctrl.md
# c5_mem_ctrl

Memory responder for the c5_cpu bus: it accepts the CPU's word-wide address, byte-write and write-data signals and services them against an external 16-bit asynchronous SRAM. Each 32-bit access is split into two halfword accesses with programmable wait states. While an access is in flight, the block holds the CPU with a pause signal. It sits inside plasma_top between c5_cpu and the board SRAM pins, selected by the SoC address decoder.

## Interface
- WAIT_CYCLES, 2: external cycles per halfword access, legal range 1..15
- EXT_AW, 19: external halfword address width
- I_clk  in  1  system clock, all state on rising edge
- I_rst_n  in  1  reset, asynchronous, active-low
- I_enable  in  1  chip select from SoC decoder, qualifies the CPU address
- I_address  in  [31:2]  CPU word address (CPU O_address)
- I_byte_we  in  [3:0]  CPU byte write enables; 0 = read; bit 3 = bits 31:24
- I_data_w  in  [31:0]  CPU write data
- O_data_r  out  [31:0]  read data to CPU
- O_mem_pause  out  1  stalls CPU while high
- O_ext_addr  out  [EXT_AW-1:0]  SRAM halfword address
- O_ext_cs  out  1  SRAM select, active-high
- O_ext_we  out  1  SRAM write strobe, active-high
- O_ext_be  out  [1:0]  SRAM byte lanes; bit 1 = bits 15:8
- O_ext_data_w  out  [15:0]  SRAM write data
- I_ext_data_r  in  [15:0]  SRAM read data

## Operation
- States: IDLE, HI, LO, DONE.
- IDLE
  - If I_enable is high: latch I_address, I_byte_we and I_data_w, load the wait counter with WAIT_CYCLES-1, go to HI.
  - If I_byte_we[3:2]==0 on a write: skip HI and go directly to LO.
- Big-endian mapping:
  - HI uses O_ext_addr = {addr[EXT_AW:2],0} and carries bits 31:16, byte enables from byte_we[3:2].
  - LO uses address LSB 1 and carries bits 15:0, byte enables from byte_we[1:0].
- HI / LO
  - O_ext_cs is high throughout.
  - O_ext_we is high throughout on writes, low on reads.
  - O_ext_be is 2'b11 on reads, the latched enables on writes.
  - The counter decrements each cycle. At 0:
    - On reads, capture I_ext_data_r into the corresponding half of O_data_r.
    - HI goes to LO. On a write with byte_we[1:0]==0, HI skips LO and goes to DONE.
    - LO goes to DONE.
- DONE: pause released for one cycle; the CPU consumes O_data_r or retires its write. Then go to IDLE.
- O_mem_pause = (IDLE & I_enable) | HI | LO. It is combinational from state and I_enable, so the CPU stalls in the same cycle it presents the address.
- Latched request is authoritative. CPU changes on I_address/I_data_w while paused are ignored. I_enable dropping mid-access does not abort; the access completes.
- O_data_r holds its last captured value outside reads. On a write it is not updated.

## Timing
- Reset values:
  - state = IDLE.
  - O_data_r, O_ext_addr, O_ext_data_w = 0.
  - O_ext_cs = O_ext_we = 0 and O_ext_be = 0.
  - O_mem_pause = 0 while I_rst_n is low.
- Read, N=WAIT_CYCLES: IDLE 1 + HI N + LO N + DONE 1 = 2N+2 cycles per access, with pause high for 2N+1 of them.
- Write touching one halfword: N+2 cycles. A write with I_byte_we=0 is a read by definition.
- Reset asserted mid-access:
  - Outputs are forced to reset values immediately, with no SRAM write completion.
  - After release, the FSM restarts from IDLE and a still-asserted I_enable starts a fresh access.
- Back-to-back accesses: DONE→IDLE→HI gives exactly one unpaused cycle between accesses.
- Counter width is 4 bits. WAIT_CYCLES=1 means a single cycle per halfword; the counter is loaded with 0.

## Structure
- Shared package c5_mem_pkg holds:
  - The FSM state typedef (IDLE, HI, LO, DONE).
  - Localparams HALF_W=16 and WAIT_W=4.
  - The byte-lane mapping constants.
- Optional sub-module c5_wait_cnt: loadable 4-bit down-counter with zero flag. Everything else stays in one module.

## Test plan
- Read, WAIT_CYCLES=2, I_address=30'h100, SRAM[0x200]=16'hDEAD, SRAM[0x201]=16'hBEEF → O_data_r=32'hDEADBEEF on the DONE cycle; pause high exactly 5 cycles; O_ext_we never high.
- Full write, I_byte_we=4'hF, I_data_w=32'h12345678 → SRAM[hi]=16'h1234, SRAM[lo]=16'h5678; O_ext_be=2'b11 in both phases; 6 cycles total.
- Byte write, I_byte_we=4'b0100, data 32'h00AB0000 → only the HI phase runs, with O_ext_be=2'b01; LO is skipped; pause high for 3 cycles; SRAM byte 0x200[7:0]=8'hAB, other bytes unchanged.
- I_enable low with arbitrary address → O_mem_pause=0 and O_ext_cs=0 for 20 cycles.
- I_rst_n pulsed low during HI of a write → O_ext_cs/O_ext_we drop asynchronously and no LO phase occurs; after release with I_enable=1, a fresh access starts from HI.
- I_address changed mid-read while paused, WAIT_CYCLES=1 → O_ext_addr keeps the latched value in LO; the returned data matches the original address.
